// File: rtl/mux4_sel_arbiter.sv
// mux4_sel_arbiter: round-robin arbiter and sequencer for a 4:1 mux select.
// One requester owns the mux path at a time. The grant is held while the owner
// keeps requesting and passes straight to the next round-robin winner when it
// releases. i_hold freezes new grants and handoffs but never revokes a grant.
// Optional feature: define ARB_WATCHDOG_EN to cap an owner at MAX_HOLD
// consecutive grant cycles whenever another requester is waiting.
module mux4_sel_arbiter #(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CNT_W    = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [3:0] i_req,
  input  logic       i_hold,
  output logic [3:0] o_gnt,
  output logic [1:0] o_sel,
  output logic       o_valid
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t     state;
  logic [1:0] rr_ptr;
  logic [1:0] winner;
  logic       found;
  logic [1:0] idx;
  logic       any_req;
  logic       take_new;
  logic       drop;
  logic       wd_rotate;

  // Round-robin search: first set request after rr_ptr, wrapping back to rr_ptr.
  always_comb begin
    winner = rr_ptr;
    found  = 1'b0;
    idx    = rr_ptr;
    for (int unsigned k = 1; k <= 4; k++) begin
      idx = rr_ptr + 2'(k);
      if (!found && i_req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  // Requests from anyone other than the current owner (o_gnt is all-zero in IDLE).
  assign any_req = |(i_req & ~o_gnt);

`ifdef ARB_WATCHDOG_EN
  logic [CNT_W-1:0] hold_cnt;

  // An owner already at or past its limit is rotated as soon as a competitor
  // shows up, so a saturated counter cannot let it keep the grant forever.
  assign wd_rotate = (hold_cnt >= CNT_W'(MAX_HOLD - 1)) && any_req && !i_hold;

  // Consecutive-grant counter for the current owner, saturating at MAX_HOLD.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      hold_cnt <= '0;
    end else if (take_new) begin
      hold_cnt <= '0;
    end else if (state == GRANT && i_req[o_sel] && hold_cnt < CNT_W'(MAX_HOLD)) begin
      hold_cnt <= hold_cnt + 1'b1;
    end
  end
`else
  assign wd_rotate = 1'b0;
`endif

  // Decide whether this edge makes a new grant, drops to idle, or keeps state.
  always_comb begin
    take_new = 1'b0;
    drop     = 1'b0;
    case (state)
      IDLE: take_new = any_req && !i_hold;
      GRANT: begin
        if (!i_req[o_sel]) begin
          if (any_req && !i_hold) take_new = 1'b1;
          else                    drop     = 1'b1;
        end else if (wd_rotate) begin
          take_new = 1'b1;
        end
      end
      default: drop = 1'b1;
    endcase
  end

  // Registered FSM and outputs; o_sel keeps its last value when idle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= IDLE;
      rr_ptr  <= 2'd3;
      o_gnt   <= '0;
      o_sel   <= '0;
      o_valid <= 1'b0;
    end else if (take_new) begin
      state   <= GRANT;
      rr_ptr  <= winner;
      o_gnt   <= 4'(1) << winner;
      o_sel   <= winner;
      o_valid <= 1'b1;
    end else if (drop) begin
      state   <= IDLE;
      o_gnt   <= '0;
      o_valid <= 1'b0;
    end
  end

endmodule
